// File: rtl/shiftreg_spi_ctrl.sv
// shiftreg_spi_ctrl: byte-serial SPI master that sequences an external
// 8-bit shift register (clr/ld/shift/din/si/dout/so).
//
// Ports:
//   CLK, clr              clock, synchronous active-high reset
//   start, nbytes         frame request and byte count (sampled in idle)
//   tx_data, tx_rd        show-ahead transmit byte and its consume pulse
//   rx_data, rx_valid     last received byte and its update pulse
//   busy, done            frame in progress, end-of-frame pulse
//   sck, cs_n, mosi, miso serial bus (CPOL=0, CPHA=0)
//   sr_clr, sr_ld, sr_shift, sr_din, sr_si, sr_dout, sr_so
//                         external shift register interface
//
// Parameters: CLK_DIV (sck half period in CLK cycles, 1..255),
//             CNT_W (width of nbytes).
// Build option: define SHIFTREG_SPI_CTRL_LSB_FIRST_EN to put bytes on
// the wire LSB first; timing is the same in both builds.

module shiftreg_spi_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 4
) (
  input  logic             CLK,
  input  logic             clr,
  input  logic             start,
  input  logic [CNT_W-1:0] nbytes,
  input  logic [7:0]       tx_data,
  output logic             tx_rd,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             sck,
  output logic             cs_n,
  input  logic             miso,
  output logic             sr_clr,
  output logic             sr_ld,
  output logic             sr_shift,
  output logic [7:0]       sr_din,
  output logic             sr_si,
  input  logic [7:0]       sr_dout,
  input  logic             sr_so,
  output logic             mosi
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] REM_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOW,
    HIGH,
    NEXT,
    FINISH,
    FDONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [7:0]       div_cnt;
  logic [7:0]       div_n;
  logic [2:0]       bit_cnt;
  logic [2:0]       bit_n;
  logic [CNT_W-1:0] byte_rem;
  logic [CNT_W-1:0] rem_n;
  logic             miso_s1;
  logic             miso_s2;
  logic             miso_q;
  logic             div_zero;
  logic             rx_load;
  logic             miso_take;
  logic             active_n;
  logic [7:0]       tx_wire;
  logic [7:0]       rx_wire;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r;
  endfunction

`ifdef SHIFTREG_SPI_CTRL_LSB_FIRST_EN
  assign tx_wire = rev8(tx_data);
  assign rx_wire = rev8(sr_dout);
`else
  assign tx_wire = tx_data;
  assign rx_wire = sr_dout;
`endif

  assign div_zero = (div_cnt == 8'd0);
  assign mosi     = sr_so;
  assign sr_clr   = clr | done;

  always_comb begin
    state_n  = state;
    div_n    = div_cnt;
    bit_n    = bit_cnt;
    rem_n    = byte_rem;
    tx_rd    = 1'b0;
    sr_ld    = 1'b0;
    sr_din   = 8'h00;
    sr_shift = 1'b0;
    sr_si    = 1'b0;
    rx_load  = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && (nbytes != '0)) begin
          rem_n   = nbytes;
          state_n = LOAD;
        end
      end
      LOAD: begin
        sr_ld   = 1'b1;
        sr_din  = tx_wire;
        tx_rd   = 1'b1;
        bit_n   = 3'd0;
        div_n   = DIV_LAST;
        state_n = LOW;
      end
      LOW: begin
        if (div_zero) begin
          div_n   = DIV_LAST;
          state_n = HIGH;
        end else begin
          div_n = div_cnt - 8'd1;
        end
      end
      HIGH: begin
        if (div_zero) begin
          sr_shift = 1'b1;
          sr_si    = miso_q;
          bit_n    = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_n = NEXT;
          end else begin
            div_n   = DIV_LAST;
            state_n = LOW;
          end
        end else begin
          div_n = div_cnt - 8'd1;
        end
      end
      NEXT: begin
        rx_load = 1'b1;
        rem_n   = byte_rem - REM_ONE;
        if (byte_rem == REM_ONE) begin
          div_n   = DIV_LAST;
          state_n = FINISH;
        end else begin
          state_n = LOAD;
        end
      end
      FINISH: begin
        if (div_zero) begin
          state_n = FDONE;
        end else begin
          div_n = div_cnt - 8'd1;
        end
      end
      FDONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // miso_q is captured at the rising edge and then keeps following the
  // synchronizer through the high phase, so the bit shifted in at the
  // falling edge has had the whole high phase to clear the two flops.
  assign miso_take = ((state == LOW) && div_zero) || (state == HIGH);

  assign active_n = (state_n == LOAD) || (state_n == LOW) ||
                    (state_n == HIGH) || (state_n == NEXT);

  always_ff @(posedge CLK) begin
    if (clr) begin
      state    <= IDLE;
      div_cnt  <= 8'd0;
      bit_cnt  <= 3'd0;
      byte_rem <= '0;
      miso_s1  <= 1'b0;
      miso_s2  <= 1'b0;
      miso_q   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      sck      <= 1'b0;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_n;
      bit_cnt  <= bit_n;
      byte_rem <= rem_n;
      miso_s1  <= miso;
      miso_s2  <= miso_s1;
      if (miso_take) begin
        miso_q <= miso_s2;
      end
      // rx_valid is registered so it rises together with the new rx_data
      rx_valid <= rx_load;
      if (rx_load) begin
        rx_data <= rx_wire;
      end
      sck  <= (state_n == HIGH);
      cs_n <= !active_n;
      busy <= (state_n != IDLE) && (state_n != FDONE);
    end
  end

endmodule

// File: tb/tb_shiftreg_spi_ctrl.sv
// tb_shiftreg_spi_ctrl: directed + randomized frames against a
// byte/bit-level reference of the SPI transfer.

module tb_shiftreg_spi_ctrl;

  localparam int D  = 2;
  localparam int CW = 4;
  localparam int BC = 2 + 16 * D;

  logic          CLK = 1'b0;
  logic          clr;
  logic          start;
  logic [CW-1:0] nbytes;
  logic [7:0]    tx_data;
  logic          tx_rd;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          busy;
  logic          done;
  logic          sck;
  logic          cs_n;
  logic          miso;
  logic          sr_clr;
  logic          sr_ld;
  logic          sr_shift;
  logic [7:0]    sr_din;
  logic          sr_si;
  logic [7:0]    sr_dout;
  logic          sr_so;
  logic          mosi;

  always #5 CLK = ~CLK;

  shiftreg_spi_ctrl #(.CLK_DIV(D), .CNT_W(CW)) dut (
    .CLK(CLK), .clr(clr), .start(start), .nbytes(nbytes),
    .tx_data(tx_data), .tx_rd(tx_rd), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy), .done(done), .sck(sck),
    .cs_n(cs_n), .miso(miso), .sr_clr(sr_clr), .sr_ld(sr_ld),
    .sr_shift(sr_shift), .sr_din(sr_din), .sr_si(sr_si),
    .sr_dout(sr_dout), .sr_so(sr_so), .mosi(mosi)
  );

  // external 8-bit MSB-first shift register
  logic [7:0] sr_q;
  assign sr_dout = sr_q;
  assign sr_so   = sr_q[7];
  always @(posedge CLK) begin
    if (sr_clr) sr_q <= 8'h00;
    else if (sr_ld) sr_q <= sr_din;
    else if (sr_shift) sr_q <= {sr_q[6:0], sr_si};
  end

  // remote device: loopback or a constant level
  logic loop;
  logic miso_tie;
  assign miso = loop ? mosi : miso_tie;

  // show-ahead transmit FIFO
  logic [7:0] tx_mem [0:15];
  logic [3:0] rd_ptr;
  logic       ptr_rst;
  assign tx_data = tx_mem[rd_ptr];
  always @(posedge CLK) begin
    if (ptr_rst) rd_ptr <= 4'd0;
    else if (tx_rd) rd_ptr <= rd_ptr + 4'd1;
  end

  // bus monitor
  logic mon_clr;
  int   n_txrd, n_rxv, n_done, n_busy, n_rise, n_schi, n_csl;
  int   n_shift, n_ovl, n_din_bad, n_mosi_bad;
  logic [7:0] rxq [$];
  logic       wbits [$];
  logic p_sck, p_mosi, p_chg;

  always @(negedge CLK) begin
    if (mon_clr) begin
      n_txrd = 0; n_rxv = 0; n_done = 0; n_busy = 0;
      n_rise = 0; n_schi = 0; n_csl = 0; n_shift = 0;
      n_ovl = 0; n_din_bad = 0; n_mosi_bad = 0;
      rxq.delete();
      wbits.delete();
    end else begin
      if (tx_rd) n_txrd++;
      if (rx_valid) begin
        n_rxv++;
        rxq.push_back(rx_data);
      end
      if (done) n_done++;
      if (busy) n_busy++;
      if (sck && !p_sck) begin
        n_rise++;
        wbits.push_back(mosi);
      end
      if (sck) n_schi++;
      if (!cs_n) n_csl++;
      if (sr_shift) n_shift++;
      if (sr_ld && sr_shift) n_ovl++;
      if (!sr_ld && sr_din != 8'h00) n_din_bad++;
      if (mosi !== p_mosi && !p_chg) n_mosi_bad++;
    end
    p_sck  = sck;
    p_mosi = mosi;
    p_chg  = sr_ld | sr_shift | sr_clr;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic prep(input bit lp, input bit tie);
    loop     = lp;
    miso_tie = tie;
    ptr_rst  = 1'b1;
    mon_clr  = 1'b1;
    @(posedge CLK) #1;
    ptr_rst  = 1'b0;
    mon_clr  = 1'b0;
  endtask

  // One frame of n bytes from tx_mem; restart_at>0 pulses start again
  // at that cycle of the frame.
  task automatic run_frame(input int n, input bit lp, input bit tie,
                           input int restart_at);
    logic [7:0] exp_rx [$];
    logic       wexp [$];
    int lat;
    int bad;
    bit got;
    for (int i = 0; i < n; i++) begin
      exp_rx.push_back(lp ? tx_mem[i] : (tie ? 8'hFF : 8'h00));
      for (int b = 0; b < 8; b++) begin
`ifdef SHIFTREG_SPI_CTRL_LSB_FIRST_EN
        wexp.push_back(tx_mem[i][b]);
`else
        wexp.push_back(tx_mem[i][7-b]);
`endif
      end
    end
    prep(lp, tie);
    start  = 1'b1;
    nbytes = CW'(n);
    @(posedge CLK) #1;
    start  = 1'b0;
    nbytes = '0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 5000) begin
      @(negedge CLK);
      lat++;
      if (lat == 1) begin
        check("busy_on", busy, 1);
        check("cs_on", cs_n, 0);
      end
      if (done) got = 1'b1;
      if (lat == restart_at) begin
        start  = 1'b1;
        nbytes = CW'(n);
      end else if (lat == restart_at + 1) begin
        start  = 1'b0;
        nbytes = '0;
      end
    end
    check("done_seen", got, 1);
    check("latency", lat, n * BC + D + 1);
    check("busy_at_done", busy, 0);
    repeat (2 * BC) @(negedge CLK);
    check("busy_after", busy, 0);
    check("n_done", n_done, 1);
    check("n_tx_rd", n_txrd, n);
    check("n_rx_valid", n_rxv, n);
    check("n_sck_rise", n_rise, 8 * n);
    check("sck_high_cyc", n_schi, 8 * n * D);
    check("cs_low_cyc", n_csl, n * BC);
    check("n_shift", n_shift, 8 * n);
    check("ld_shift_ovl", n_ovl, 0);
    check("din_nonzero", n_din_bad, 0);
    check("mosi_glitch", n_mosi_bad, 0);
    check("rx_count", rxq.size(), n);
    for (int i = 0; i < n && i < rxq.size(); i++) begin
      check("rx_byte", rxq[i], exp_rx[i]);
    end
    check("wire_count", wbits.size(), wexp.size());
    bad = 0;
    for (int k = 0; k < wexp.size() && k < wbits.size(); k++) begin
      if (wbits[k] !== wexp[k]) bad++;
    end
    check("wire_bits", bad, 0);
    @(posedge CLK) #1;
  endtask

  initial begin
    int n;
    bit ok;
    clr      = 1'b1;
    start    = 1'b0;
    nbytes   = '0;
    loop     = 1'b0;
    miso_tie = 1'b0;
    ptr_rst  = 1'b1;
    mon_clr  = 1'b1;
    for (int i = 0; i < 16; i++) tx_mem[i] = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_sck", sck, 0);
    check("rst_cs_n", cs_n, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tx_rd", tx_rd, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_sr_ld", sr_ld, 0);
    check("rst_sr_shift", sr_shift, 0);
    check("rst_sr_clr", sr_clr, 1);
    clr = 1'b0;
    @(posedge CLK) #1;
    check("idle_sr_clr", sr_clr, 0);

    // single byte loopback
    tx_mem[0] = 8'hA5;
    run_frame(1, 1'b1, 1'b0, 0);

    // three bytes, miso tied high
    tx_mem[0] = 8'h01;
    tx_mem[1] = 8'h80;
    tx_mem[2] = 8'hFF;
    run_frame(3, 1'b0, 1'b1, 0);

    // zero-length request is ignored
    prep(1'b1, 1'b0);
    start  = 1'b1;
    nbytes = '0;
    @(posedge CLK) #1;
    start  = 1'b0;
    repeat (40) @(negedge CLK);
    check("zero_busy", n_busy, 0);
    check("zero_tx_rd", n_txrd, 0);
    check("zero_done", n_done, 0);
    @(posedge CLK) #1;

    // start while busy is ignored
    tx_mem[0] = 8'h3C;
    tx_mem[1] = 8'hC3;
    run_frame(2, 1'b1, 1'b0, 20);

    // reset in the middle of byte 2
    for (int i = 0; i < 3; i++) tx_mem[i] = 8'($urandom);
    prep(1'b1, 1'b0);
    start  = 1'b1;
    nbytes = CW'(3);
    @(posedge CLK) #1;
    start  = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge CLK);
      if (n_txrd == 2) ok = 1'b1;
    end
    check("abort_reach_b2", ok, 1);
    repeat (3 * D + 1) @(negedge CLK);
    clr = 1'b1;
    @(negedge CLK);
    check("abort_cs_n", cs_n, 1);
    check("abort_sck", sck, 0);
    check("abort_busy", busy, 0);
    check("abort_sr_clr", sr_clr, 1);
    clr = 1'b0;
    repeat (20) @(negedge CLK);
    check("abort_no_done", n_done, 0);
    @(posedge CLK) #1;
    tx_mem[0] = 8'h5A;
    tx_mem[1] = 8'h96;
    run_frame(2, 1'b1, 1'b0, 0);

    // longest frame
    for (int i = 0; i < 15; i++) tx_mem[i] = 8'($urandom);
    run_frame(15, 1'b1, 1'b0, 0);

    // random frames
    for (int f = 0; f < 5; f++) begin
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) tx_mem[i] = 8'($urandom);
      run_frame(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
